// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared tri bus with break-before-make gap and hold limit.
// Optional sticky contention checker built when TRISTATE_ARB_CONTENTION_CHECK_EN is defined.
module tristate_bus_arbiter #(
   parameter int N_SRC = 4,
   parameter int WIDTH = 8,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD = 8,
   localparam int OW = $clog2(N_SRC)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC-1:0]         req,
   input  logic [N_SRC*WIDTH-1:0]   data_in,
   output logic [N_SRC-1:0]         grant,
   output tri   [WIDTH-1:0]         bus,
   output logic [OW-1:0]            owner_id,
   output logic                     busy,
   output logic                     contention_err
);
   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
   state_t state, state_nx;
   logic [OW-1:0] last_owner, pick;
   logic pick_ok, load;
   logic [7:0] hold_cnt;
   logic [3:0] gap_cnt;
   // walk downward so the nearest source after last_owner is assigned last and wins
   always_comb begin
      pick = '0;
      pick_ok = 1'b0;
      for (int k = N_SRC; k >= 1; k--) begin
         if (req[(int'(last_owner) + k) % N_SRC]) begin
            pick = OW'((int'(last_owner) + k) % N_SRC);
            pick_ok = 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      load = 1'b0;
      case (state)
         IDLE: begin
            state_nx = pick_ok ? DRIVE : IDLE;
            load = pick_ok;
         end
         DRIVE: state_nx = (req[owner_id] && hold_cnt < 8'(MAX_HOLD)) ? DRIVE : GAP;
         GAP: begin
            state_nx = (gap_cnt != 4'd1) ? GAP : (pick_ok ? DRIVE : IDLE);
            load = (gap_cnt == 4'd1) && pick_ok;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         owner_id <= '0;
         last_owner <= OW'(N_SRC - 1);
         hold_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            grant <= {{(N_SRC-1){1'b0}}, 1'b1} << pick;
            owner_id <= pick;
            last_owner <= pick;
            hold_cnt <= 8'd1;
         end else if (state == DRIVE && state_nx == DRIVE) begin
            hold_cnt <= hold_cnt + 8'd1;
         end else if (state == DRIVE) begin
            grant <= '0;
            gap_cnt <= 4'(TURNAROUND);
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end
   assign busy = |grant;
   for (genvar i = 0; i < N_SRC; i++) begin : g_buf
      assign bus = grant[i] ? data_in[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
   end
`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
   logic [3:0] z_cnt;
   logic busy_q;
   // z_cnt counts bus-idle edges since the last fall, saturating so long idle periods stay legal
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_cnt <= 4'hf;
         busy_q <= 1'b0;
         contention_err <= 1'b0;
      end else begin
         busy_q <= busy;
         z_cnt <= busy ? 4'd0 : (z_cnt == 4'hf ? z_cnt : z_cnt + 4'd1);
         contention_err <= contention_err | ($countones(grant) > 1) |
                           (busy & ~busy_q & (z_cnt < 4'(TURNAROUND)));
      end
   end
`else
   assign contention_err = 1'b0;
`endif
endmodule
